// File: rtl/collision_scheduler.sv
// collision_scheduler: one rectangle-overlap comparator time-shared over every object pair per frame.
// Latency: i_Start sampled at edge T -> o_Done during cycle T+P*E+P*B+B+2 (T+23 with default sizes).
// Backpressure: none; i_Start is ignored while busy and in the DONE cycle, never queued.
//
// Ports:
//   i_Clk, i_Rst                 clock, synchronous active-high reset
//   i_Start                      frame tick, starts one scan from IDLE
//   i_*State                     alive bits for enemies, enemy bullets, player bullets, player
//   i_*Position                  packed {x[9:0], y[8:0]} top-left per slot; player supplies x only
//   o_Busy / o_Done              scan in progress / one-cycle pulse when hit vectors are valid
//   o_*Hit                       hit vectors, held until the next DONE
//
// Optional feature: define COLLISION_SYMMETRIC_CHECK_EN to test both Overlap(A,B) and Overlap(B,A)
// per pair, which also catches a small rectangle lying entirely inside a larger one.
module collision_scheduler #(
    parameter int MAX_ENEMY         = 3,
    parameter int MAX_ENEMY_BULLET  = 3,
    parameter int MAX_PLAYER_BULLET = 3,
    parameter int ENEMY_WIDTH       = 36,
    parameter int ENEMY_HEIGHT      = 24,
    parameter int PLAYER_WIDTH      = 24,
    parameter int PLAYER_HEIGHT     = 36,
    parameter int BULLET_WIDTH      = 4,
    parameter int BULLET_HEIGHT     = 16,
    parameter int PLAYER_Y          = 372,
    parameter int MONITOR_HEIGHT    = 480
) (
    input  logic                            i_Clk,
    input  logic                            i_Rst,
    input  logic                            i_Start,
    input  logic [MAX_ENEMY-1:0]            i_EnemyState,
    input  logic [MAX_ENEMY_BULLET-1:0]     i_EnemyBulletState,
    input  logic [MAX_PLAYER_BULLET-1:0]    i_PlayerBulletState,
    input  logic                            i_PlayerState,
    input  logic [19*MAX_ENEMY-1:0]         i_EnemyPosition,
    input  logic [19*MAX_ENEMY_BULLET-1:0]  i_EnemyBulletPosition,
    input  logic [19*MAX_PLAYER_BULLET-1:0] i_PlayerBulletPosition,
    input  logic [9:0]                      i_PlayerPosition,
    output logic                            o_Busy,
    output logic                            o_Done,
    output logic [MAX_ENEMY-1:0]            o_EnemyHit,
    output logic [MAX_ENEMY_BULLET-1:0]     o_EnemyBulletHit,
    output logic [MAX_PLAYER_BULLET-1:0]    o_PlayerBulletHit,
    output logic                            o_PlayerHit
);

    localparam int EW = (MAX_ENEMY > 1) ? $clog2(MAX_ENEMY) : 1;
    localparam int BW = (MAX_ENEMY_BULLET > 1) ? $clog2(MAX_ENEMY_BULLET) : 1;
    localparam int PW = (MAX_PLAYER_BULLET > 1) ? $clog2(MAX_PLAYER_BULLET) : 1;

    localparam logic [EW-1:0] E_LAST = EW'(MAX_ENEMY - 1);
    localparam logic [BW-1:0] B_LAST = BW'(MAX_ENEMY_BULLET - 1);
    localparam logic [PW-1:0] P_LAST = PW'(MAX_PLAYER_BULLET - 1);

    localparam logic [9:0] EN_W = 10'(ENEMY_WIDTH);
    localparam logic [8:0] EN_H = 9'(ENEMY_HEIGHT);
    localparam logic [9:0] PL_W = 10'(PLAYER_WIDTH);
    localparam logic [8:0] PL_H = 9'(PLAYER_HEIGHT);
    localparam logic [9:0] BU_W = 10'(BULLET_WIDTH);
    localparam logic [8:0] BU_H = 9'(BULLET_HEIGHT);
    localparam logic [8:0] PL_Y = 9'(PLAYER_Y);
    // An enemy bullet whose top is below this line has left the bottom of the screen.
    localparam logic [8:0] EB_Y_LIMIT = 9'(MONITOR_HEIGHT - BULLET_HEIGHT);

    typedef enum logic [2:0] {IDLE, SNAP, PB_EN, PB_EB, EB_PL, DONE} state_t;
    state_t state, nextState;

    // Frame snapshot
    logic [MAX_ENEMY-1:0]         enAlive;
    logic [MAX_ENEMY_BULLET-1:0]  ebAlive;
    logic [MAX_PLAYER_BULLET-1:0] pbAlive;
    logic                         plAlive;
    logic [9:0] enX [MAX_ENEMY];
    logic [8:0] enY [MAX_ENEMY];
    logic [9:0] ebX [MAX_ENEMY_BULLET];
    logic [8:0] ebY [MAX_ENEMY_BULLET];
    logic [9:0] pbX [MAX_PLAYER_BULLET];
    logic [8:0] pbY [MAX_PLAYER_BULLET];
    logic [9:0] plX;

    logic [PW-1:0] pIdx;
    logic [EW-1:0] eIdx;
    logic [BW-1:0] bIdx;

    logic [MAX_ENEMY-1:0]         accEn, hitEn;
    logic [MAX_ENEMY_BULLET-1:0]  accEb, hitEb, ebBorder;
    logic [MAX_PLAYER_BULLET-1:0] accPb, hitPb, pbBorder;
    logic                         accPl, hitPl;

    logic [9:0] aX, aW, bX, bW;
    logic [8:0] aY, aH, bY, bH;
    logic       pairAlive, pairHit;

    // B's left or right edge inside A's x span, and B's top or bottom edge inside A's y span.
    // Far edges are widened by one bit so they never wrap.
    function automatic logic overlap(
        input logic [9:0] ax, input logic [8:0] ay, input logic [9:0] aw, input logic [8:0] ah,
        input logic [9:0] bx, input logic [8:0] by, input logic [9:0] bw, input logic [8:0] bh
    );
        logic [10:0] ax2, bx2;
        logic [9:0]  ay2, by2;
        logic        h, v;
        ax2 = {1'b0, ax} + {1'b0, aw};
        bx2 = {1'b0, bx} + {1'b0, bw};
        ay2 = {1'b0, ay} + {1'b0, ah};
        by2 = {1'b0, by} + {1'b0, bh};
        h = ((ax <= bx) && ({1'b0, bx} <= ax2)) || (({1'b0, ax} <= bx2) && (bx2 <= ax2));
        v = ((ay <= by) && ({1'b0, by} <= ay2)) || (({1'b0, ay} <= by2) && (by2 <= ay2));
        return h & v;
    endfunction

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (i_Start) nextState = SNAP;
            SNAP:    nextState = PB_EN;
            PB_EN:   if (pIdx == P_LAST && eIdx == E_LAST) nextState = PB_EB;
            PB_EB:   if (pIdx == P_LAST && bIdx == B_LAST) nextState = EB_PL;
            EB_PL:   if (bIdx == B_LAST) nextState = DONE;
            DONE:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Route the current pair onto the shared comparator.
    always_comb begin
        aX = pbX[pIdx];
        aY = pbY[pIdx];
        aW = BU_W;
        aH = BU_H;
        bX = enX[eIdx];
        bY = enY[eIdx];
        bW = EN_W;
        bH = EN_H;
        pairAlive = 1'b0;
        case (state)
            PB_EN: pairAlive = pbAlive[pIdx] & enAlive[eIdx];
            PB_EB: begin
                bX = ebX[bIdx];
                bY = ebY[bIdx];
                bW = BU_W;
                bH = BU_H;
                pairAlive = pbAlive[pIdx] & ebAlive[bIdx];
            end
            EB_PL: begin
                aX = ebX[bIdx];
                aY = ebY[bIdx];
                bX = plX;
                bY = PL_Y;
                bW = PL_W;
                bH = PL_H;
                pairAlive = ebAlive[bIdx] & plAlive;
            end
            default: pairAlive = 1'b0;
        endcase
    end

`ifdef COLLISION_SYMMETRIC_CHECK_EN
    assign pairHit = pairAlive & (overlap(aX, aY, aW, aH, bX, bY, bW, bH) |
                                  overlap(bX, bY, bW, bH, aX, aY, aW, aH));
`else
    assign pairHit = pairAlive & overlap(aX, aY, aW, aH, bX, bY, bW, bH);
`endif

    always_comb begin
        ebBorder = '0;
        pbBorder = '0;
        for (int k = 0; k < MAX_ENEMY_BULLET; k++)
            ebBorder[k] = ebAlive[k] & (ebY[k] > EB_Y_LIMIT);
        for (int k = 0; k < MAX_PLAYER_BULLET; k++)
            pbBorder[k] = pbAlive[k] & (pbY[k][8:2] == 7'd0);
    end

    // In DONE the finished accumulators drive the outputs directly so they are valid alongside o_Done;
    // the same values are registered on leaving DONE and held until the next scan completes.
    assign o_Busy            = (state == SNAP) || (state == PB_EN) || (state == PB_EB) || (state == EB_PL);
    assign o_Done            = (state == DONE);
    assign o_EnemyHit        = (state == DONE) ? accEn : hitEn;
    assign o_EnemyBulletHit  = (state == DONE) ? (accEb | ebBorder) : hitEb;
    assign o_PlayerBulletHit = (state == DONE) ? (accPb | pbBorder) : hitPb;
    assign o_PlayerHit       = (state == DONE) ? accPl : hitPl;

    // Positions need no reset: they are only read after SNAP has loaded them.
    always_ff @(posedge i_Clk) begin
        if (state == SNAP) begin
            for (int k = 0; k < MAX_ENEMY; k++) begin
                enX[k] <= i_EnemyPosition[19*k+9 +: 10];
                enY[k] <= i_EnemyPosition[19*k +: 9];
            end
            for (int k = 0; k < MAX_ENEMY_BULLET; k++) begin
                ebX[k] <= i_EnemyBulletPosition[19*k+9 +: 10];
                ebY[k] <= i_EnemyBulletPosition[19*k +: 9];
            end
            for (int k = 0; k < MAX_PLAYER_BULLET; k++) begin
                pbX[k] <= i_PlayerBulletPosition[19*k+9 +: 10];
                pbY[k] <= i_PlayerBulletPosition[19*k +: 9];
            end
            plX <= i_PlayerPosition;
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state   <= IDLE;
            pIdx    <= '0;
            eIdx    <= '0;
            bIdx    <= '0;
            enAlive <= '0;
            ebAlive <= '0;
            pbAlive <= '0;
            plAlive <= 1'b0;
            accEn   <= '0;
            accEb   <= '0;
            accPb   <= '0;
            accPl   <= 1'b0;
            hitEn   <= '0;
            hitEb   <= '0;
            hitPb   <= '0;
            hitPl   <= 1'b0;
        end else begin
            state <= nextState;
            case (state)
                SNAP: begin
                    enAlive <= i_EnemyState;
                    ebAlive <= i_EnemyBulletState;
                    pbAlive <= i_PlayerBulletState;
                    plAlive <= i_PlayerState;
                    accEn   <= '0;
                    accEb   <= '0;
                    accPb   <= '0;
                    accPl   <= 1'b0;
                    pIdx    <= '0;
                    eIdx    <= '0;
                    bIdx    <= '0;
                end
                PB_EN: begin
                    if (pairHit) begin
                        accPb[pIdx] <= 1'b1;
                        accEn[eIdx] <= 1'b1;
                    end
                    if (eIdx == E_LAST) begin
                        eIdx <= '0;
                        pIdx <= (pIdx == P_LAST) ? '0 : pIdx + 1'b1;
                    end else begin
                        eIdx <= eIdx + 1'b1;
                    end
                end
                PB_EB: begin
                    if (pairHit) begin
                        accPb[pIdx] <= 1'b1;
                        accEb[bIdx] <= 1'b1;
                    end
                    // Both indices wrap to zero at the end, so EB_PL starts at bullet 0.
                    if (bIdx == B_LAST) begin
                        bIdx <= '0;
                        pIdx <= (pIdx == P_LAST) ? '0 : pIdx + 1'b1;
                    end else begin
                        bIdx <= bIdx + 1'b1;
                    end
                end
                EB_PL: begin
                    if (pairHit) begin
                        accEb[bIdx] <= 1'b1;
                        accPl       <= 1'b1;
                    end
                    bIdx <= bIdx + 1'b1;
                end
                DONE: begin
                    hitEn <= accEn;
                    hitEb <= accEb | ebBorder;
                    hitPb <= accPb | pbBorder;
                    hitPl <= accPl;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_collision_scheduler.sv
// tb_collision_scheduler: directed and randomized scans of collision_scheduler against a pair-list model.
// Latency: expects o_Done exactly 23 cycles after the i_Start edge with default sizes.
// Backpressure: checks that extra i_Start pulses during a scan and in DONE are dropped.
module tb_collision_scheduler;

    localparam int E = 3;
    localparam int B = 3;
    localparam int P = 3;

    logic           i_Clk = 1'b0;
    logic           i_Rst;
    logic           i_Start;
    logic [E-1:0]   i_EnemyState;
    logic [B-1:0]   i_EnemyBulletState;
    logic [P-1:0]   i_PlayerBulletState;
    logic           i_PlayerState;
    logic [19*E-1:0] i_EnemyPosition;
    logic [19*B-1:0] i_EnemyBulletPosition;
    logic [19*P-1:0] i_PlayerBulletPosition;
    logic [9:0]     i_PlayerPosition;
    logic           o_Busy;
    logic           o_Done;
    logic [E-1:0]   o_EnemyHit;
    logic [B-1:0]   o_EnemyBulletHit;
    logic [P-1:0]   o_PlayerBulletHit;
    logic           o_PlayerHit;

    collision_scheduler dut (
        .i_Clk                  (i_Clk),
        .i_Rst                  (i_Rst),
        .i_Start                (i_Start),
        .i_EnemyState           (i_EnemyState),
        .i_EnemyBulletState     (i_EnemyBulletState),
        .i_PlayerBulletState    (i_PlayerBulletState),
        .i_PlayerState          (i_PlayerState),
        .i_EnemyPosition        (i_EnemyPosition),
        .i_EnemyBulletPosition  (i_EnemyBulletPosition),
        .i_PlayerBulletPosition (i_PlayerBulletPosition),
        .i_PlayerPosition       (i_PlayerPosition),
        .o_Busy                 (o_Busy),
        .o_Done                 (o_Done),
        .o_EnemyHit             (o_EnemyHit),
        .o_EnemyBulletHit       (o_EnemyBulletHit),
        .o_PlayerBulletHit      (o_PlayerBulletHit),
        .o_PlayerHit            (o_PlayerHit)
    );

    always #5 i_Clk = ~i_Clk;

    int checks = 0;
    int errors = 0;

    // Scene description: plain integers, one entry per object.
    int enX[E], enY[E], ebX[B], ebY[B], pbX[P], pbY[P], plX;
    bit enA[E], ebA[B], pbA[P], plA;

    logic [E-1:0] expEn;
    logic [B-1:0] expEb;
    logic [P-1:0] expPb;
    logic         expPl;

    // Observations from one scan
    int           doneAt, doneCnt;
    logic [63:0]  busyMask;
    logic [E-1:0] obsEn, endEn;
    logic [B-1:0] obsEb, endEb;
    logic [P-1:0] obsPb, endPb;
    logic         obsPl, endPl;

    localparam logic [63:0] FULL_BUSY = 64'h7F_FFFE; // cycles 1..22

    function automatic bit ovl(int ax, int ay, int aw, int ah, int bx, int by, int bw, int bh);
        bit h, v;
        h = (ax <= bx && bx <= ax + aw) || (ax <= bx + bw && bx + bw <= ax + aw);
        v = (ay <= by && by <= ay + ah) || (ay <= by + bh && by + bh <= ay + ah);
        return h && v;
    endfunction

    function automatic bit pairHits(int ax, int ay, int aw, int ah, int bx, int by, int bw, int bh);
`ifdef COLLISION_SYMMETRIC_CHECK_EN
        return ovl(ax, ay, aw, ah, bx, by, bw, bh) || ovl(bx, by, bw, bh, ax, ay, aw, ah);
`else
        return ovl(ax, ay, aw, ah, bx, by, bw, bh);
`endif
    endfunction

    task automatic computeModel();
        expEn = '0; expEb = '0; expPb = '0; expPl = 1'b0;
        for (int p = 0; p < P; p++)
            for (int e = 0; e < E; e++)
                if (pbA[p] && enA[e] && pairHits(pbX[p], pbY[p], 4, 16, enX[e], enY[e], 36, 24)) begin
                    expPb[p] = 1'b1; expEn[e] = 1'b1;
                end
        for (int p = 0; p < P; p++)
            for (int b = 0; b < B; b++)
                if (pbA[p] && ebA[b] && pairHits(pbX[p], pbY[p], 4, 16, ebX[b], ebY[b], 4, 16)) begin
                    expPb[p] = 1'b1; expEb[b] = 1'b1;
                end
        for (int b = 0; b < B; b++)
            if (ebA[b] && plA && pairHits(ebX[b], ebY[b], 4, 16, plX, 372, 24, 36)) begin
                expEb[b] = 1'b1; expPl = 1'b1;
            end
        for (int b = 0; b < B; b++)
            if (ebA[b] && ebY[b] > 480 - 16) expEb[b] = 1'b1;
        for (int p = 0; p < P; p++)
            if (pbA[p] && pbY[p] < 4) expPb[p] = 1'b1;
    endtask

    task automatic drive();
        for (int k = 0; k < E; k++) begin
            i_EnemyPosition[19*k +: 19] = {10'(enX[k]), 9'(enY[k])};
            i_EnemyState[k] = enA[k];
        end
        for (int k = 0; k < B; k++) begin
            i_EnemyBulletPosition[19*k +: 19] = {10'(ebX[k]), 9'(ebY[k])};
            i_EnemyBulletState[k] = ebA[k];
        end
        for (int k = 0; k < P; k++) begin
            i_PlayerBulletPosition[19*k +: 19] = {10'(pbX[k]), 9'(pbY[k])};
            i_PlayerBulletState[k] = pbA[k];
        end
        i_PlayerPosition = 10'(plX);
        i_PlayerState = plA;
    endtask

    // Everything alive, each object parked in its own empty spot so that nothing touches.
    task automatic park();
        for (int k = 0; k < 3; k++) begin
            enX[k] = 500 + 50 * k; enY[k] = 200; enA[k] = 1'b1;
            ebX[k] = 500 + 50 * k; ebY[k] = 300; ebA[k] = 1'b1;
            pbX[k] = 500 + 50 * k; pbY[k] = 400; pbA[k] = 1'b1;
        end
        plX = 202; plA = 1'b1;
        drive();
    endtask

    task automatic randomizeInputs();
        for (int k = 0; k < 3; k++) begin
            enX[k] = $urandom_range(190, 240); enY[k] = $urandom_range(20, 60);
            enA[k] = ($urandom_range(0, 3) != 0);
            ebX[k] = $urandom_range(190, 240);
            ebY[k] = ($urandom_range(0, 1) == 1) ? $urandom_range(20, 70) : $urandom_range(360, 480);
            ebA[k] = ($urandom_range(0, 3) != 0);
            pbX[k] = $urandom_range(190, 240); pbY[k] = $urandom_range(0, 70);
            pbA[k] = ($urandom_range(0, 3) != 0);
        end
        plX = $urandom_range(180, 240);
        plA = ($urandom_range(0, 3) != 0);
        drive();
    endtask

    // Pulses i_Start now (just after a negedge), then watches 45 cycles. Cycle k is sampled at the
    // k-th negedge after the start edge. Extra start pulses / a reset pulse can be placed on cycle k.
    task automatic runScan(input int startA, input int startB, input int rstAt, input bit scramble);
        doneAt = -1; doneCnt = 0; busyMask = '0;
        obsEn = 'x; obsEb = 'x; obsPb = 'x; obsPl = 1'bx;
        i_Start = 1'b1;
        for (int k = 1; k <= 45; k++) begin
            @(negedge i_Clk);
            busyMask[k] = o_Busy;
            if (o_Done === 1'b1) begin
                doneCnt++;
                if (doneAt < 0) begin
                    doneAt = k;
                    obsEn = o_EnemyHit; obsEb = o_EnemyBulletHit;
                    obsPb = o_PlayerBulletHit; obsPl = o_PlayerHit;
                end
            end
            i_Start = (k == startA || k == startB);
            i_Rst   = (k == rstAt);
            if (scramble && k == 3) randomizeInputs();
        end
        i_Start = 1'b0; i_Rst = 1'b0;
        endEn = o_EnemyHit; endEb = o_EnemyBulletHit; endPb = o_PlayerBulletHit; endPl = o_PlayerHit;
    endtask

    task automatic test_reset();
        i_Rst = 1'b1; i_Start = 1'b0;
        park();
        repeat (3) @(negedge i_Clk);
        checks++; if (o_Busy !== 1'b0) begin errors++; $display("FAIL reset busy: got %b want 0", o_Busy); end
        checks++; if (o_Done !== 1'b0) begin errors++; $display("FAIL reset done: got %b want 0", o_Done); end
        checks++; if ({o_EnemyHit, o_EnemyBulletHit, o_PlayerBulletHit, o_PlayerHit} !== 10'd0) begin
            errors++; $display("FAIL reset hits: got %b want 0", {o_EnemyHit, o_EnemyBulletHit, o_PlayerBulletHit, o_PlayerHit});
        end
        i_Rst = 1'b0;
        @(negedge i_Clk);
    endtask

    task automatic test_all_dead();
        park();
        for (int k = 0; k < 3; k++) begin enA[k] = 0; ebA[k] = 0; pbA[k] = 0; end
        plA = 0;
        pbY[1] = 2; ebY[0] = 470; // border positions must not count for dead bullets
        drive();
        runScan(0, 0, 0, 0);
        checks++; if (doneAt !== 23) begin errors++; $display("FAIL dead latency: got %0d want 23", doneAt); end
        checks++; if (doneCnt !== 1) begin errors++; $display("FAIL dead done count: got %0d want 1", doneCnt); end
        checks++; if (busyMask !== FULL_BUSY) begin errors++; $display("FAIL dead busy: got %h want %h", busyMask, FULL_BUSY); end
        checks++; if ({obsEn, obsEb, obsPb, obsPl} !== 10'd0) begin
            errors++; $display("FAIL dead hits: got %b want 0", {obsEn, obsEb, obsPb, obsPl});
        end
    endtask

    task automatic test_pb_enemy();
        park();
        // Bullet spans x 298..302 and so covers the enemy's left edge at 300.
        pbX[0] = 298; pbY[0] = 95; enX[1] = 300; enY[1] = 100;
        drive();
        runScan(0, 0, 0, 0);
        checks++; if (obsEn !== 3'b010) begin errors++; $display("FAIL pbEn enemyHit: got %b want 010", obsEn); end
        checks++; if (obsPb !== 3'b001) begin errors++; $display("FAIL pbEn pbHit: got %b want 001", obsPb); end
        checks++; if ({obsEb, obsPl} !== 4'b0) begin errors++; $display("FAIL pbEn others: got %b want 0", {obsEb, obsPl}); end
    endtask

    task automatic test_player();
        park();
        // Bullet x 200..204 holds the player's left edge 202; y 370..386 holds the top edge 372.
        ebX[2] = 200; ebY[2] = 370; plX = 202;
        for (int alive = 1; alive >= 0; alive--) begin
            plA = alive[0];
            drive();
            runScan(0, 0, 0, 0);
            checks++; if (obsPl !== plA) begin errors++; $display("FAIL player hit alive=%0d: got %b want %b", alive, obsPl, plA); end
            checks++; if (obsEb !== (plA ? 3'b100 : 3'b000)) begin
                errors++; $display("FAIL player ebHit alive=%0d: got %b want %b", alive, obsEb, (plA ? 3'b100 : 3'b000));
            end
        end
    endtask

    task automatic test_border();
        int          eby[4]  = '{465, 464, 300, 300};
        int          pby[4]  = '{400, 400, 3, 4};
        logic [2:0]  wEb[4]  = '{3'b001, 3'b000, 3'b000, 3'b000};
        logic [2:0]  wPb[4]  = '{3'b000, 3'b000, 3'b010, 3'b000};
        for (int i = 0; i < 4; i++) begin
            park();
            ebY[0] = eby[i]; pbY[1] = pby[i];
            drive();
            runScan(0, 0, 0, 0);
            checks++; if (obsEb !== wEb[i]) begin errors++; $display("FAIL border%0d ebHit: got %b want %b", i, obsEb, wEb[i]); end
            checks++; if (obsPb !== wPb[i]) begin errors++; $display("FAIL border%0d pbHit: got %b want %b", i, obsPb, wPb[i]); end
        end
    endtask

    task automatic test_containment();
        logic [2:0] want;
`ifdef COLLISION_SYMMETRIC_CHECK_EN
        want = 3'b001;
`else
        want = 3'b000;
`endif
        park();
        pbX[0] = 310; pbY[0] = 105; enX[0] = 300; enY[0] = 100;
        drive();
        runScan(0, 0, 0, 0);
        checks++; if (obsEn !== want) begin errors++; $display("FAIL contain enemyHit: got %b want %b", obsEn, want); end
        checks++; if (obsPb !== want) begin errors++; $display("FAIL contain pbHit: got %b want %b", obsPb, want); end
    endtask

    task automatic test_back_to_back_start();
        park();
        runScan(5, 23, 0, 0);
        checks++; if (doneCnt !== 1) begin errors++; $display("FAIL extraStart done count: got %0d want 1", doneCnt); end
        checks++; if (doneAt !== 23) begin errors++; $display("FAIL extraStart latency: got %0d want 23", doneAt); end
        checks++; if (busyMask !== FULL_BUSY) begin errors++; $display("FAIL extraStart busy: got %h want %h", busyMask, FULL_BUSY); end
    endtask

    task automatic test_reset_midscan();
        park();
        pbX[0] = 298; pbY[0] = 95; enX[1] = 300; enY[1] = 100;
        drive();
        runScan(0, 0, 0, 0);
        checks++; if (endEn !== 3'b010) begin errors++; $display("FAIL midRst preload: got %b want 010", endEn); end
        runScan(0, 0, 10, 0);
        checks++; if (doneCnt !== 0) begin errors++; $display("FAIL midRst done count: got %0d want 0", doneCnt); end
        checks++; if (busyMask !== 64'h7FE) begin errors++; $display("FAIL midRst busy: got %h want 7fe", busyMask); end
        checks++; if ({endEn, endEb, endPb, endPl} !== 10'd0) begin
            errors++; $display("FAIL midRst outputs: got %b want 0", {endEn, endEb, endPb, endPl});
        end
        runScan(0, 0, 0, 0);
        checks++; if (doneAt !== 23) begin errors++; $display("FAIL postRst latency: got %0d want 23", doneAt); end
        checks++; if ({obsEn, obsPb} !== 6'b010_001) begin errors++; $display("FAIL postRst hits: got %b want 010001", {obsEn, obsPb}); end
    endtask

    // Random scenes; odd iterations also rewrite every input after SNAP to prove the snapshot holds.
    task automatic test_random();
        for (int it = 0; it < 40; it++) begin
            randomizeInputs();
            computeModel();
            runScan(0, 0, 0, it[0]);
            checks++; if (doneAt !== 23) begin errors++; $display("FAIL rand%0d latency: got %0d want 23", it, doneAt); end
            checks++; if (obsEn !== expEn) begin errors++; $display("FAIL rand%0d enemyHit: got %b want %b", it, obsEn, expEn); end
            checks++; if (obsEb !== expEb) begin errors++; $display("FAIL rand%0d ebHit: got %b want %b", it, obsEb, expEb); end
            checks++; if (obsPb !== expPb) begin errors++; $display("FAIL rand%0d pbHit: got %b want %b", it, obsPb, expPb); end
            checks++; if (obsPl !== expPl) begin errors++; $display("FAIL rand%0d playerHit: got %b want %b", it, obsPl, expPl); end
            checks++; if ({endEn, endEb, endPb, endPl} !== {expEn, expEb, expPb, expPl}) begin
                errors++; $display("FAIL rand%0d hold: got %b want %b", it, {endEn, endEb, endPb, endPl}, {expEn, expEb, expPb, expPl});
            end
        end
    endtask

    initial begin
        test_reset();
        test_all_dead();
        test_pb_enemy();
        test_player();
        test_border();
        test_containment();
        test_back_to_back_start();
        test_reset_midscan();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
